seq3_scan: RTL and testbench
============================

SEQ3_SCAN -- requirements
Module: seq3_scan

Interface
REQ-001 Parameter W, default 16, meaning scanned word width in bits; legal range 4..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  word offer from upstream.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  W  word to scan; bit 0 is scanned first.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_count  output  4  number of windows with three equal consecutive bits.
REQ-010 out_found  output  1  high when out_count is nonzero.
REQ-011 out_first  output  4  lowest matching window index; present only under REQ-030.

Function
REQ-012 The block SHALL implement three states, IDLE, SCAN and DONE, encoded in a registered state variable.
REQ-013 In IDLE, in_ready SHALL be 1, and out_valid SHALL be 0.
REQ-014 On an edge in IDLE with in_valid=1, the block SHALL latch in_data, clear count and window index, and enter SCAN (the accept edge).
REQ-015 A window j SHALL match when bits j, j+1 and j+2 of the latched word are all 0 or all 1; windows overlap, j = 0..W-3.
REQ-016 In SCAN, each edge SHALL evaluate window j = index, increment count on match, and increment index.
REQ-017 The edge evaluating window W-3 SHALL also move the state to DONE.
REQ-018 out_valid SHALL rise exactly W-2 edges after the accept edge (14 for W=16).
REQ-019 In SCAN, in_ready and out_valid SHALL be 0; in_valid is ignored and in_data may change freely.
REQ-020 In DONE, out_valid SHALL be 1, with out_count, out_found and out_first held stable.
REQ-021 On an edge in DONE with out_ready=1, the block SHALL return to IDLE.
REQ-022 With out_ready=0, DONE SHALL persist indefinitely with outputs unchanged.
REQ-023 No new word SHALL be accepted on the same edge as result hand-off; the next accept occurs at the earliest one edge later from IDLE.
REQ-024 out_count SHALL never wrap; its maximum is W-2 (14 at W=16).
REQ-025 out_count, out_found and out_first SHALL be driven from registers only, not from combinational paths on in_data.

Reset
REQ-026 While rst=1 at an edge, the state SHALL become IDLE, and count, index and the latched word SHALL be cleared.
REQ-027 After reset, outputs SHALL be in_ready=1, out_valid=0, out_count=0, out_found=0 and out_first=0.
REQ-028 Reset asserted mid-SCAN or in DONE SHALL abort the operation; no result is delivered, and the partial result is discarded.
REQ-029 rst SHALL have priority over in_valid and out_ready on the same edge.

Configuration
REQ-030 The macro SEQ3_FIRSTPOS_EN SHALL control out_first.
- When defined: out_first port exists.
  - It is loaded with index j on the first matching window of a scan.
  - It is unchanged on later matches and is 0 when out_found=0.
- When undefined: no out_first port and no associated registers; all other behaviour is identical.

Verification
REQ-031 Scenario, all zeros: accept in_data=16'h0000 -> out_valid after 14 edges, out_count=14, out_found=1, out_first=0.
REQ-032 Scenario, alternating bits:
- in_data=16'h5555 -> out_count=0, out_found=0, out_first=0.
- in_data=16'h000F -> out_count=12, out_first=0.
- in_data=16'h0006 -> out_count=11, out_first=3.
REQ-033 Scenario, backpressure:
- Hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1 and outputs are stable.
- Raise out_ready -> IDLE next edge, in_ready=1.
REQ-034 Scenario, busy input: pulse in_valid with 16'hFFFF during SCAN of 16'h5555 -> ignored; result out_count=0.
REQ-035 Scenario, mid-scan reset:
- Assert rst at scan edge 5 of 16'h0000 -> IDLE, out_valid never asserts.
- Next word 16'h000F -> out_count=12.

Source files
------------

// File: rtl/seq3_scan.sv
// Scans a latched W-bit word, one overlapping 3-bit window per clock, counting runs of three equal bits.
// Optional first-match position output is enabled by defining SEQ3_FIRSTPOS_EN.
module seq3_scan #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_count,
    output logic         out_found
`ifdef SEQ3_FIRSTPOS_EN
    ,
    output logic [3:0]   out_first
`endif
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_IDX  = CW'(W - 3);
    localparam logic [CW-1:0] MAX_COUNT = CW'(W - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          found_q, found_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
`ifdef SEQ3_FIRSTPOS_EN
    logic [CW-1:0] first_q, first_d;
`endif

    logic [W-1:0]  shifted;
    logic [2:0]    win;
    logic          match;

    // Window under evaluation: bits idx, idx+1, idx+2 of the latched word.
    always_comb begin
        shifted = word_q >> idx_q;
        win     = shifted[2:0];
        match   = (&win) | ~(|win);
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        count_d = count_q;
        found_d = found_q;
`ifdef SEQ3_FIRSTPOS_EN
        first_d = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    count_d = '0;
                    found_d = 1'b0;
`ifdef SEQ3_FIRSTPOS_EN
                    first_d = '0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    if (count_q != MAX_COUNT) begin
                        count_d = count_q + 4'd1;
                    end
                    found_d = 1'b1;
`ifdef SEQ3_FIRSTPOS_EN
                    if (!found_q) begin
                        first_d = idx_q;
                    end
`endif
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ3_FIRSTPOS_EN
            first_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            found_q     <= found_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ3_FIRSTPOS_EN
            first_q     <= first_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign out_found = found_q;
`ifdef SEQ3_FIRSTPOS_EN
    assign out_first = first_q;
`endif

endmodule

// File: tb/tb_seq3_scan.sv
// Self-checking bench for seq3_scan: vector table through a scoreboard queue plus
// hand-written backpressure, busy-input, hand-off and mid-scan reset sequences.
module tb_seq3_scan;

    typedef struct {
        logic [15:0] data;
        int          cnt;
        int          found;
        int          first;
        int          hold;
        bit          busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_count;
    logic        out_found;
`ifdef SEQ3_FIRSTPOS_EN
    logic [3:0]  out_first;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb[$];
    vec_t tbl[10];

    seq3_scan #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_found (out_found)
`ifdef SEQ3_FIRSTPOS_EN
        ,
        .out_first (out_first)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: count 3-bit runs over windows 0..13.
    function automatic vec_t mk(input logic [15:0] d);
        vec_t v;
        bit   seen = 1'b0;
        v.data = d; v.cnt = 0; v.found = 0; v.first = 0; v.hold = 0; v.busy = 1'b0;
        for (int j = 0; j < 14; j++) begin
            if (d[j] == d[j+1] && d[j+1] == d[j+2]) begin
                if (!seen) v.first = j;
                seen = 1'b1;
                v.cnt++;
            end
        end
        v.found = (v.cnt != 0) ? 1 : 0;
        return v;
    endfunction

    function automatic vec_t mkv(input logic [15:0] d, input int c, input int f, input int fp,
                                 input int hold, input bit busy);
        vec_t v;
        v.data = d; v.cnt = c; v.found = f; v.first = fp; v.hold = hold; v.busy = busy;
        return v;
    endfunction

    // Accept one word, scan it, compare result from the scoreboard, then hand off.
    task automatic run_word(input vec_t v, input bit offer_at_handoff);
        int   n;
        int   lat;
        vec_t e;
        logic [3:0] c0;
        logic f0;
        bit   stable;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = v.data;
        sb.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        chk("scan_in_ready", int'(in_ready), 0);
        chk("scan_out_valid", int'(out_valid), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (v.busy && lat == 3) begin
                in_valid = 1'b1;
                in_data  = 16'hFFFF;
            end else begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 14);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("count", int'(out_count), e.cnt);
                chk("found", int'(out_found), e.found);
`ifdef SEQ3_FIRSTPOS_EN
                chk("first", int'(out_first), e.first);
`endif
            end
        end
        if (v.hold > 0) begin
            c0 = out_count;
            f0 = out_found;
            stable = 1'b1;
            repeat (v.hold) begin
                @(negedge clk);
                if (!out_valid || out_count != c0 || out_found != f0) stable = 1'b0;
            end
            chk("hold_stable", int'(stable), 1);
        end
        out_ready = 1'b1;
        if (offer_at_handoff) begin
            in_valid = 1'b1;
            in_data  = 16'h0006;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handoff_in_ready", int'(in_ready), 1);
        chk("handoff_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        int  n;
        bit  saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_found", int'(out_found), 0);
`ifdef SEQ3_FIRSTPOS_EN
        chk("rst_first", int'(out_first), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        tbl[0] = mkv(16'h0000, 14, 1, 0, 0, 1'b0);
        tbl[1] = mkv(16'h5555, 0, 0, 0, 0, 1'b0);
        tbl[2] = mkv(16'h000F, 12, 1, 0, 0, 1'b0);
        tbl[3] = mkv(16'h0006, 11, 1, 3, 0, 1'b0);
        tbl[4] = mkv(16'hFFFF, 14, 1, 0, 20, 1'b0);
        tbl[5] = mkv(16'h5555, 0, 0, 0, 0, 1'b1);
        tbl[6] = mkv(16'hAAA8, 1, 1, 0, 3, 1'b0);
        for (int i = 7; i < 10; i++) tbl[i] = mk(16'($urandom));

        for (int i = 0; i < 10; i++) run_word(tbl[i], 1'b0);

        // Offer on the hand-off edge must wait for the following edge.
        run_word(mkv(16'h000F, 12, 1, 0, 0, 1'b0), 1'b1);
        run_word(mkv(16'h0006, 11, 1, 3, 0, 1'b0), 1'b0);

        // Reset at scan edge 5 aborts the word; nothing is delivered.
        in_valid = 1'b1;
        in_data  = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_count", int'(out_count), 0);
        chk("abort_found", int'(out_found), 0);
        saw_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
            n++;
        end
        chk("abort_no_valid", int'(saw_valid), 0);
        run_word(mkv(16'h000F, 12, 1, 0, 0, 1'b0), 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
